// File: rtl/adsr_envelope_pkg.sv
// Shared constants and state type for the ADSR envelope block.
// The optional exponential release tail is selected with ENV_EXP_RELEASE_EN.
package adsr_envelope_pkg;

    localparam int unsigned SYNTH_WIDTH = 16;
    localparam int unsigned ENV_WIDTH   = 16;
    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_DECAY,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

endpackage

// File: rtl/env_vca.sv
// Two-stage VCA: signed sample times unsigned level, then arithmetic shift
// back to sample width (floor rounding). Valid is delayed to match.
module env_vca
    import adsr_envelope_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned LEVEL_W  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic                       valid_i,
    input  logic        [LEVEL_W-1:0]  level_i,
    output logic signed [SAMPLE_W-1:0] sample_o,
    output logic                       valid_o
);

    localparam int unsigned PROD_W = SAMPLE_W + LEVEL_W + 1;

    logic signed [PROD_W-1:0]   sample_ext;
    logic signed [PROD_W-1:0]   level_ext;
    logic signed [PROD_W-1:0]   prod_d, prod_q;
    logic                       valid1_q;
    logic signed [SAMPLE_W-1:0] sample_d, sample_q;
    logic                       valid2_q;

    // Level is zero-extended so it always acts as a non-negative gain.
    assign sample_ext = {{(LEVEL_W + 1){sample_i[SAMPLE_W-1]}}, sample_i};
    assign level_ext  = {{(SAMPLE_W + 1){1'b0}}, level_i};
    assign prod_d     = sample_ext * level_ext;
    assign sample_d   = SAMPLE_W'(prod_q >>> LEVEL_W);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q   <= '0;
            valid1_q <= 1'b0;
            sample_q <= '0;
            valid2_q <= 1'b0;
        end else begin
            valid1_q <= valid_i;
            valid2_q <= valid1_q;
            if (valid_i) begin
                prod_q <= prod_d;
            end
            if (valid1_q) begin
                sample_q <= sample_d;
            end
        end
    end

    assign sample_o = sample_q;
    assign valid_o  = valid2_q;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate-driven FSM stepping the level on sample strobes,
// feeding env_vca. Define ENV_EXP_RELEASE_EN for an exponential release tail.
module adsr_envelope
    import adsr_envelope_pkg::*;
#(
    parameter int unsigned SYNTH_WIDTH = adsr_envelope_pkg::SYNTH_WIDTH,
    parameter int unsigned ENV_WIDTH   = adsr_envelope_pkg::ENV_WIDTH
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic signed [SYNTH_WIDTH-1:0] sample_in,
    input  logic                          sample_valid_in,
    input  logic                          gate_in,
    input  logic        [ENV_WIDTH-1:0]   attack_rate_in,
    input  logic        [ENV_WIDTH-1:0]   decay_rate_in,
    input  logic        [ENV_WIDTH-1:0]   sustain_level_in,
    input  logic        [ENV_WIDTH-1:0]   release_rate_in,
    output logic signed [SYNTH_WIDTH-1:0] sample_out,
    output logic                          sample_valid_out,
    output logic        [ENV_WIDTH-1:0]   env_out,
    output logic                          active_out
);

    localparam logic [ENV_WIDTH-1:0] LVL_MAX = '1;

    env_state_t           state_q, state_d;
    logic [ENV_WIDTH-1:0] level_q, level_d;
    logic                 gate_q;
    logic                 gate_rise, gate_fall;
    logic [ENV_WIDTH:0]   att_sum;
    logic [ENV_WIDTH:0]   rel_dec;
    logic                 rel_instant;

    assign gate_rise = gate_in & ~gate_q;
    assign gate_fall = ~gate_in & gate_q;
    assign att_sum   = {1'b0, level_q} + {1'b0, attack_rate_in};

`ifdef ENV_EXP_RELEASE_EN
    assign rel_dec     = {1'b0, level_q >> release_rate_in[3:0]} + (ENV_WIDTH + 1)'(1);
    assign rel_instant = 1'b0;
`else
    assign rel_dec     = {1'b0, release_rate_in};
    assign rel_instant = (release_rate_in == '0);
`endif

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        // Any gate edge pre-empts the level step on that cycle.
        if (gate_rise) begin
            state_d = ENV_ATTACK;
        end else if (gate_fall) begin
            if (state_q inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN}) begin
                state_d = ENV_RELEASE;
            end
        end else if (sample_valid_in) begin
            unique case (state_q)
                ENV_ATTACK: begin
                    if (attack_rate_in == '0 || att_sum >= {1'b0, LVL_MAX}) begin
                        level_d = LVL_MAX;
                        state_d = ENV_DECAY;
                    end else begin
                        level_d = att_sum[ENV_WIDTH-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (decay_rate_in == '0 || level_q <= sustain_level_in ||
                        (level_q - sustain_level_in) <= decay_rate_in) begin
                        level_d = sustain_level_in;
                        state_d = ENV_SUSTAIN;
                    end else begin
                        level_d = level_q - decay_rate_in;
                    end
                end
                ENV_SUSTAIN: begin
                    level_d = sustain_level_in;
                end
                ENV_RELEASE: begin
                    if (rel_instant || rel_dec >= {1'b0, level_q}) begin
                        level_d = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        level_d = level_q - rel_dec[ENV_WIDTH-1:0];
                    end
                end
                default: begin
                    level_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ENV_IDLE;
            level_q <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            gate_q  <= gate_in;
        end
    end

    env_vca #(
        .SAMPLE_W (SYNTH_WIDTH),
        .LEVEL_W  (ENV_WIDTH)
    ) u_vca (
        .clk_i    (clk_in),
        .rst_ni   (rst_in),
        .sample_i (sample_in),
        .valid_i  (sample_valid_in),
        .level_i  (level_q),
        .sample_o (sample_out),
        .valid_o  (sample_valid_out)
    );

    assign env_out    = level_q;
    assign active_out = (state_q != ENV_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with an abstract envelope/VCA model checked
// every clock, plus literal expectations at the key points of each phase.
module tb_adsr_envelope;
    import adsr_envelope_pkg::*;

    localparam int SW   = SYNTH_WIDTH;
    localparam int EW   = ENV_WIDTH;
    localparam int EMAX = (1 << EW) - 1;

    logic                 clk;
    logic                 rst_n;
    logic signed [SW-1:0] sample;
    logic                 valid;
    logic                 gate;
    logic [EW-1:0]        attack, decay, sustain, rel;
    logic signed [SW-1:0] sample_out;
    logic                 valid_out;
    logic [EW-1:0]        env_out;
    logic                 active_out;

    int n_checks = 0;
    int n_fail   = 0;

    adsr_envelope #(
        .SYNTH_WIDTH (SW),
        .ENV_WIDTH   (EW)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_n),
        .sample_in        (sample),
        .sample_valid_in  (valid),
        .gate_in          (gate),
        .attack_rate_in   (attack),
        .decay_rate_in    (decay),
        .sustain_level_in (sustain),
        .release_rate_in  (rel),
        .sample_out       (sample_out),
        .sample_valid_out (valid_out),
        .env_out          (env_out),
        .active_out       (active_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phases as plain integers, gain as exact floor division.
    localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;
    int m_phase = P_IDLE, m_level = 0, m_out = 0, m_e1 = 0;
    bit m_gate = 0, m_v1 = 0, m_v2 = 0;

    function automatic int floor_scale(input int s, input int lvl);
        longint p, d;
        p = longint'(s) * longint'(lvl);
        d = longint'(1) << EW;
        if (p >= 0) return int'(p / d);
        return int'(-((-p + d - 1) / d));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit rise, fall;
        int nl, r;
        if (!rst_n) begin
            m_phase = P_IDLE; m_level = 0; m_out = 0; m_e1 = 0;
            m_gate = 0; m_v1 = 0; m_v2 = 0;
        end else begin
            rise = gate && !m_gate;
            fall = !gate && m_gate;
            m_gate = gate;
            if (m_v1) m_out = m_e1;
            m_v2 = m_v1;
            m_v1 = valid;
            if (valid) m_e1 = floor_scale(int'(sample), m_level);
            if (rise) begin
                m_phase = P_ATT;
            end else if (fall) begin
                if (m_phase == P_ATT || m_phase == P_DEC || m_phase == P_SUS) m_phase = P_REL;
            end else if (valid) begin
                case (m_phase)
                    P_ATT: begin
                        nl = (attack == 0) ? EMAX : m_level + int'(attack);
                        if (nl >= EMAX) begin m_level = EMAX; m_phase = P_DEC; end
                        else m_level = nl;
                    end
                    P_DEC: begin
                        nl = (decay == 0) ? int'(sustain) : m_level - int'(decay);
                        if (nl <= int'(sustain)) begin m_level = int'(sustain); m_phase = P_SUS; end
                        else m_level = nl;
                    end
                    P_SUS: m_level = int'(sustain);
                    P_REL: begin
`ifdef ENV_EXP_RELEASE_EN
                        r  = int'(rel) % 16;
                        nl = m_level - ((m_level >> r) + 1);
`else
                        nl = (rel == 0) ? 0 : m_level - int'(rel);
`endif
                        if (nl <= 0) begin m_level = 0; m_phase = P_IDLE; end
                        else m_level = nl;
                    end
                    default: m_level = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_env", longint'(env_out), longint'(m_level));
            check("model_active", longint'(active_out), longint'(m_phase != P_IDLE));
            check("model_vout", longint'(valid_out), longint'(m_v2));
            check("model_sout", longint'(sample_out), longint'(m_out));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One strobe every 4 clocks, checking the 2-cycle output valid alignment.
    task automatic strobe(input int s);
        sample = SW'(s);
        valid  = 1'b1;
        tick(1);
        valid  = 1'b0;
        check("vout_at_1", longint'(valid_out), 0);
        tick(1);
        check("vout_at_2", longint'(valid_out), 1);
        tick(1);
        check("vout_at_3", longint'(valid_out), 0);
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0; gate = 1'b0; valid = 1'b0; sample = '0;
        attack = '0; decay = '0; sustain = '0; rel = '0;
        #12;
        check("rst_env", longint'(env_out), 0);
        check("rst_active", longint'(active_out), 0);
        check("rst_sout", longint'(sample_out), 0);
        check("rst_vout", longint'(valid_out), 0);
        #1 rst_n = 1'b1;
        tick(1);

        attack = 16'd16384; decay = 16'd10000; sustain = 16'd40000;
`ifdef ENV_EXP_RELEASE_EN
        rel = 16'd2;
`else
        rel = 16'd12000;
`endif
        gate = 1'b1;
        tick(1);
        check("att_active", longint'(active_out), 1);
        check("att_start", longint'(env_out), 0);
        strobe(0);    check("att_1", longint'(env_out), 16384);
        strobe(0);    check("att_2", longint'(env_out), 32768);
        strobe(0);    check("att_3", longint'(env_out), 49152);
        strobe(1000); check("att_4", longint'(env_out), 65535);
        check("vca_49152", longint'(sample_out), 750);

        strobe(1000);  check("dec_1", longint'(env_out), 55535);
        check("vca_65535", longint'(sample_out), 999);
        strobe(-1000); check("vca_neg_floor", longint'(sample_out), -848);
        check("dec_2", longint'(env_out), 45535);
        strobe(0);     check("dec_clamp", longint'(env_out), 40000);
        strobe(0);     check("sus_hold", longint'(env_out), 40000);
        sustain = 16'd30000;
        strobe(0);     check("sus_live", longint'(env_out), 30000);

        sustain = 16'd32768;
        strobe(0);     check("sus_32768", longint'(env_out), 32768);
        strobe(1000);  check("vca_pos", longint'(sample_out), 500);
        strobe(-1000); check("vca_neg", longint'(sample_out), -500);
        strobe(-1001); check("vca_neg_half", longint'(sample_out), -501);
        sustain = 16'd30000;
        strobe(0);     check("sus_back", longint'(env_out), 30000);

        sample = 16'sd200; valid = 1'b1; tick(1);
        sample = -16'sd200; tick(1);
        valid = 1'b0; tick(3);
        check("b2b_last", longint'(sample_out), -92);

        gate = 1'b0;
        tick(1);
        check("rel_edge_hold", longint'(env_out), 30000);
        check("rel_active", longint'(active_out), 1);
`ifdef ENV_EXP_RELEASE_EN
        strobe(0); check("rel_exp_1", longint'(env_out), 22499);
        strobe(0);
`else
        strobe(0); check("rel_1", longint'(env_out), 18000);
        strobe(0); check("rel_2", longint'(env_out), 6000);
`endif
        gate = 1'b1; valid = 1'b1; sample = '0;
        tick(1);
        valid = 1'b0;
        check("retrig_active", longint'(active_out), 1);
`ifndef ENV_EXP_RELEASE_EN
        check("retrig_hold", longint'(env_out), 6000);
`endif
        tick(3);
        strobe(0);
`ifndef ENV_EXP_RELEASE_EN
        check("retrig_step", longint'(env_out), 22384);
`endif
        gate = 1'b0;
        tick(1);
        for (int i = 0; i < 300 && active_out; i++) strobe(0);
        check("rel_idle", longint'(active_out), 0);
        check("rel_zero", longint'(env_out), 0);

        attack = '0; decay = '0; sustain = 16'd20000; rel = '0;
        gate = 1'b1;
        tick(1);
        strobe(0); check("att_inst", longint'(env_out), 65535);
        strobe(0); check("dec_inst", longint'(env_out), 20000);
        gate = 1'b0;
        tick(1);
        strobe(0); check("rel_inst", longint'(env_out), 0);
        check("rel_inst_idle", longint'(active_out), 0);

        attack = 16'd1000;
        gate = 1'b1;
        tick(1);
        strobe(500); check("pre_rst_1", longint'(env_out), 1000);
        strobe(500); check("pre_rst_sout", longint'(sample_out), 7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_env", longint'(env_out), 0);
        check("arst_active", longint'(active_out), 0);
        check("arst_sout", longint'(sample_out), 0);
        check("arst_vout", longint'(valid_out), 0);
        #3 rst_n = 1'b1;
        tick(1);
        check("post_rst_rise", longint'(active_out), 1);
        check("post_rst_env", longint'(env_out), 0);
        strobe(0); check("post_rst_step", longint'(env_out), 1000);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
